pc_next_sequencer: RTL and testbench

- Next-PC stage directly upstream of Program_Counter: computes the value driven onto its pc_in from its pc_out plus the decoded control-flow op.
- Supports sequential increment, conditional relative branch, absolute jump, and call/return via an internal hardware return-address stack.
- Supports halt and stall.
- Holds the only control-flow state in fetch: stack contents, stack pointer, run/halt FSM and error flags.

---
 rtl/pc_next_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_next_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_next_sequencer.sv
// rtl/pc_next_sequencer.sv - next-PC select with return-address stack and run/halt FSM
// Optional macro PC_SEQ_STACK_CHECK_EN: sticky stack error flags that also halt the sequencer.
module pc_next_sequencer #(
  parameter int PC_WIDTH     = 11,
  parameter int DEPTH        = 4,
  parameter int OFFSET_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic                         cond,
  input  logic [OFFSET_WIDTH-1:0]      offset,
  input  logic [PC_WIDTH-1:0]          target,
  input  logic [PC_WIDTH-1:0]          pc_current,
  output logic [PC_WIDTH-1:0]          pc_next,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       depth_q, depth_d;
  logic [PC_WIDTH-1:0] stack_q [DEPTH];
  logic [PC_WIDTH-1:0] inc, br_tgt, top;
  logic [AW-1:0]       top_idx, push_idx;
  logic                full, empty, active, push_en;

  assign inc      = pc_current + 1'b1;
  assign br_tgt   = inc + PC_WIDTH'($signed(offset));
  assign full     = (depth_q == SW'(DEPTH));
  assign empty    = (depth_q == '0);
  // Ops only take effect when running, unstalled and out of reset
  assign active   = !reset && !stall && (state_q == S_RUN);
  assign top_idx  = AW'(depth_q - 1'b1);
  assign push_idx = AW'(depth_q);
  assign top      = stack_q[top_idx];

`ifdef PC_SEQ_STACK_CHECK_EN
  logic ovf_evt, unf_evt, ovf_q, ovf_d, unf_q, unf_d;
  assign ovf_evt = active && (op == OP_CALL) && full;
  assign unf_evt = active && (op == OP_RET) && empty;
  assign ovf_d   = ovf_q | ovf_evt;
  assign unf_d   = unf_q | unf_evt;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
`else
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

  always_comb begin
    pc_next = inc;
    state_d = state_q;
    depth_d = depth_q;
    push_en = 1'b0;
    if (reset) begin
      pc_next = '0;
    end else if (!active) begin
      pc_next = pc_current;
    end else begin
      case (op)
        OP_BRANCH: if (cond) pc_next = br_tgt;
        OP_JUMP:   pc_next = target;
        OP_CALL: begin
          pc_next = target;
          if (!full) begin
            push_en = 1'b1;
            depth_d = depth_q + 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pc_next = top;
            depth_d = depth_q - 1'b1;
          end
        end
        OP_HALT: begin
          pc_next = pc_current;
          state_d = S_HALTED;
        end
        default: ;
      endcase
    end
`ifdef PC_SEQ_STACK_CHECK_EN
    if (ovf_evt || unf_evt) state_d = S_HALTED;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) stack_q[push_idx] <= inc;
  end

  assign halted      = (state_q == S_HALTED);
  assign stack_depth = depth_q;

endmodule

// File: tb/tb_pc_next_sequencer.sv
// tb/tb_pc_next_sequencer.sv - directed and random checks of pc_next_sequencer against a queue-based model
module tb_pc_next_sequencer;

`ifdef PC_SEQ_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [2:0] NEXT = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3, RET = 3'd4, HALT = 3'd5;
  localparam int MAXD = 4;

  logic        clock = 1'b0;
  logic        reset, stall, cond;
  logic [2:0]  op;
  logic [7:0]  offset;
  logic [10:0] target, pc_current, pc_next;
  logic        halted, stack_overflow, stack_underflow;
  logic [2:0]  stack_depth;

  int checks = 0;
  int failures = 0;

  int m_stack[$];
  bit m_halted = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  pc_next_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall), .op(op), .cond(cond),
    .offset(offset), .target(target), .pc_current(pc_current), .pc_next(pc_next),
    .halted(halted), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input logic r, input logic s, input logic [2:0] o,
                                    input logic c, input logic [7:0] off,
                                    input logic [10:0] tgt, input logic [10:0] pc);
    int inc;
    inc = (int'(pc) + 1) % 2048;
    if (r) return 0;
    if (s || m_halted) return int'(pc);
    case (o)
      BRANCH: return c ? ((int'(pc) + 1 + int'($signed(off)) + 4096) % 2048) : inc;
      JUMP:   return int'(tgt);
      CALL:   return int'(tgt);
      RET:    return (m_stack.size() == 0) ? inc : m_stack[$];
      HALT:   return int'(pc);
      default: return inc;
    endcase
  endfunction

  task automatic model_update(input logic r, input logic s, input logic [2:0] o, input logic [10:0] pc);
    if (r) begin
      m_stack.delete();
      m_halted = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!s && !m_halted) begin
      if (o == CALL) begin
        if (m_stack.size() < MAXD) m_stack.push_back((int'(pc) + 1) % 2048);
        else if (CHK) begin m_ovf = 1'b1; m_halted = 1'b1; end
      end else if (o == RET) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else if (CHK) begin m_unf = 1'b1; m_halted = 1'b1; end
      end else if (o == HALT) begin
        m_halted = 1'b1;
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic [2:0] o,
                      input logic c, input logic [7:0] off, input logic [10:0] tgt,
                      input logic [10:0] pc);
    int exp;
    reset = r; stall = s; op = o; cond = c; offset = off; target = tgt; pc_current = pc;
    #2;
    exp = model_next(r, s, o, c, off, tgt, pc);
    chk({tag, "/pc_next"}, {21'd0, pc_next}, exp);
    @(posedge clock);
    model_update(r, s, o, pc);
    #1;
    chk({tag, "/depth"}, {29'd0, stack_depth}, m_stack.size());
    chk({tag, "/halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, "/ovf"}, {31'd0, stack_overflow}, {31'd0, m_ovf});
    chk({tag, "/unf"}, {31'd0, stack_underflow}, {31'd0, m_unf});
  endtask

  initial begin
    logic [2:0] rop;
    // Reset sequencing and increment
    step("rst0", 1, 0, NEXT, 0, 8'h00, 11'h000, 11'h000);
    step("rst1", 1, 0, NEXT, 0, 8'h00, 11'h000, 11'h000);
    step("inc0", 0, 0, NEXT, 0, 8'h00, 11'h000, 11'h000);
    step("inc1", 0, 0, NEXT, 0, 8'h00, 11'h000, 11'h001);
    step("inc2", 0, 0, NEXT, 0, 8'h00, 11'h000, 11'h002);
    step("op7",  0, 0, 3'd7, 0, 8'h00, 11'h000, 11'h003);
    // Branch and wrap
    step("br_t",   0, 0, BRANCH, 1, 8'hFC, 11'h000, 11'h010);
    step("br_nt",  0, 0, BRANCH, 0, 8'hFC, 11'h000, 11'h010);
    step("wrap",   0, 0, NEXT,   0, 8'h00, 11'h000, 11'h7FF);
    step("br_wr",  0, 0, BRANCH, 1, 8'h05, 11'h000, 11'h7FE);
    step("jump",   0, 0, JUMP,   0, 8'h00, 11'h456, 11'h123);
    // Call/return nesting
    step("call1", 0, 0, CALL, 0, 8'h00, 11'h100, 11'h020);
    step("call2", 0, 0, CALL, 0, 8'h00, 11'h200, 11'h105);
    step("ret1",  0, 0, RET,  0, 8'h00, 11'h000, 11'h200);
    step("ret2",  0, 0, RET,  0, 8'h00, 11'h000, 11'h106);
    // Overflow at full stack
    for (int i = 0; i < 5; i++)
      step("ovf_call", 0, 0, CALL, 0, 8'h00, 11'h300 + 11'(i), 11'h060 + 11'(i));
    step("ovf_after", 0, 0, NEXT, 0, 8'h00, 11'h000, 11'h304);
    step("rst_u", 1, 0, NEXT, 0, 8'h00, 11'h000, 11'h000);
    // Underflow at empty stack
    step("unf_ret", 0, 0, RET,  0, 8'h00, 11'h000, 11'h030);
    step("unf_aft", 0, 0, NEXT, 0, 8'h00, 11'h000, 11'h031);
    step("rst_s", 1, 0, NEXT, 0, 8'h00, 11'h000, 11'h000);
    // Stall priority
    step("st_call", 0, 1, CALL, 0, 8'h00, 11'h300, 11'h040);
    step("st_halt", 0, 1, HALT, 0, 8'h00, 11'h000, 11'h040);
    step("st_free", 0, 0, NEXT, 0, 8'h00, 11'h000, 11'h040);
    // Halt, then reset with a partly full stack
    step("halt",   0, 0, HALT, 0, 8'h00, 11'h000, 11'h050);
    step("h_jump", 0, 0, JUMP, 0, 8'h00, 11'h222, 11'h050);
    step("h_call", 0, 0, CALL, 0, 8'h00, 11'h222, 11'h050);
    step("rst_h", 1, 0, NEXT, 0, 8'h00, 11'h000, 11'h050);
    for (int i = 0; i < 3; i++)
      step("d3_call", 0, 0, CALL, 0, 8'h00, 11'h400 + 11'(i), 11'h070 + 11'(i));
    step("rst_d3", 1, 0, CALL, 0, 8'h00, 11'h500, 11'h402);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == HALT && $urandom_range(0, 3) != 0) rop = CALL;
      step("rnd", ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0), rop,
           1'($urandom), 8'($urandom), 11'($urandom), 11'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
